// File: rtl/riscv_instr_line_responder_if.sv
// riscv_instr_line_responder_if: line fetch handshake and SRAM port bundle
interface riscv_instr_line_responder_if #(
   parameter int MEM_ADDR_WIDTH = 12
);
   logic                      instr_req;
   logic [31:0]               instr_addr;
   logic                      instr_gnt;
   logic                      instr_rvalid;
   logic [127:0]              instr_rdata;
   logic                      mem_req;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr;
   logic                      mem_gnt;
   logic [31:0]               mem_rdata;
   logic                      busy;
   modport slave (
      input  instr_req, instr_addr, mem_gnt, mem_rdata,
      output instr_gnt, instr_rvalid, instr_rdata, mem_req, mem_addr, busy
   );
   modport master (
      output instr_req, instr_addr, mem_gnt, mem_rdata,
      input  instr_gnt, instr_rvalid, instr_rdata, mem_req, mem_addr, busy
   );
endinterface

// File: rtl/riscv_instr_line_responder.sv
// riscv_instr_line_responder: reads four SRAM words per line request and returns them as one 128-bit line
module riscv_instr_line_responder #(
   parameter int MEM_ADDR_WIDTH = 12
) (
   input logic clk,
   input logic rst_n,
   riscv_instr_line_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, WAIT, RESP} state_t;
   state_t                    state, state_d;
   logic [MEM_ADDR_WIDTH-3:0] line_q;
   logic [1:0]                issue_cnt;
   logic [2:0]                capture_cnt;
   logic                      rd_pending;
   logic [95:0]               line_buf;
   logic [127:0]              rdata_q;
   logic                      accept, word_gnt, last_cap, unused_addr;
   assign accept      = (state == IDLE || state == RESP) && bus.instr_req;
   assign word_gnt    = state == FETCH && bus.mem_gnt;
   assign last_cap    = rd_pending && capture_cnt == 3'd3;
   assign unused_addr = ^{bus.instr_addr[31:MEM_ADDR_WIDTH+2], bus.instr_addr[3:0]};
   // state register; async reset abandons any line in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_d;
   end
   // next state and outputs; a new line is accepted only in IDLE or alongside the response
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = accept ? FETCH : IDLE;
         FETCH:   state_d = word_gnt && issue_cnt == 2'd3 ? WAIT : FETCH;
         WAIT:    state_d = last_cap ? RESP : WAIT;
         default: state_d = accept ? FETCH : IDLE;
      endcase
      bus.instr_gnt    = accept;
      bus.instr_rvalid = state == RESP;
      bus.instr_rdata  = rdata_q;
      bus.mem_req      = state == FETCH;
      bus.mem_addr     = state == FETCH ? {line_q, issue_cnt} : '0;
      bus.busy         = state != IDLE;
   end
   // line address, word counters and assembly; words shift in low-first, the last one lands straight in the output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q      <= '0;
         issue_cnt   <= '0;
         capture_cnt <= '0;
         rd_pending  <= 1'b0;
         line_buf    <= '0;
         rdata_q     <= '0;
      end else begin
         rd_pending <= word_gnt;
         if (accept) begin
            line_q      <= bus.instr_addr[MEM_ADDR_WIDTH+1:4];
            issue_cnt   <= '0;
            capture_cnt <= '0;
         end else begin
            if (word_gnt) issue_cnt <= issue_cnt + 2'd1;
            if (rd_pending) capture_cnt <= capture_cnt + 3'd1;
         end
         if (rd_pending) line_buf <= {bus.mem_rdata, line_buf[95:32]};
         if (last_cap) rdata_q <= {bus.mem_rdata, line_buf};
      end
   end
endmodule

// File: tb/tb_riscv_instr_line_responder.sv
// tb_riscv_instr_line_responder: transaction-level model plus directed line fetches
module tb_riscv_instr_line_responder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   riscv_instr_line_responder_if bus ();
   riscv_instr_line_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // SRAM: word at address a holds 0x1000_0000 + a, returned one cycle after a granted request
   always @(posedge clk) bus.mem_rdata <= (bus.mem_req && bus.mem_gnt) ? 32'h1000_0000 + 32'(bus.mem_addr) : 32'hDEAD_BEEF;
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [127:0] line_data(input logic [9:0] l);
      logic [127:0] d;
      for (int k = 0; k < 4; k++) d[32*k +: 32] = 32'h1000_0000 + 32'({l, 2'(k)});
      return d;
   endfunction
   // model: one outstanding line; four word grants; rvalid two cycles after the fourth grant
   bit           active = 0;
   logic [9:0]   mline = '0;
   int           issued = 0;
   int           after4 = 0;
   logic [127:0] last_line = '0;
   always @(negedge clk) begin
      logic e_rv, e_mreq, e_gnt;
      logic [11:0] e_maddr;
      if (!rst_n) begin
         active = 0;
         issued = 0;
         after4 = 0;
         last_line = '0;
      end
      e_rv    = rst_n && active && issued == 4 && after4 == 2;
      e_mreq  = rst_n && active && issued < 4;
      e_maddr = e_mreq ? {mline, 2'(issued)} : 12'h0;
      e_gnt   = rst_n && bus.instr_req && (!active || e_rv);
      if (e_rv) last_line = line_data(mline);
      check("gnt", bus.instr_gnt, e_gnt);
      check("rvalid", bus.instr_rvalid, e_rv);
      check("rdata", bus.instr_rdata, last_line);
      check("mem_req", bus.mem_req, e_mreq);
      check("mem_addr", bus.mem_addr, e_maddr);
      check("busy", bus.busy, rst_n && active);
      if (rst_n) begin
         if (active && issued == 4) after4++;
         if (e_mreq && bus.mem_gnt) begin
            issued++;
            after4 = 1;
         end
         if (e_rv) active = 0;
         if (e_gnt) begin
            active = 1;
            mline  = bus.instr_addr[13:4];
            issued = 0;
            after4 = 0;
         end
      end
   end
   task automatic request(input logic [31:0] a);
      @(posedge clk); #1;
      bus.instr_req = 1'b1;
      bus.instr_addr = a;
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      check("grant same cycle", bus.instr_gnt, 1'b1);
   endtask
   // runs a granted line to its rvalid; mode 1 requests nxt in the rvalid cycle, mode 2 also holds req on pre before it
   task automatic run(input string name, input logic [15:0] seq, input int seqlen, input int mode,
                      input logic [31:0] pre, input logic [31:0] nxt, input int exp_lat,
                      input logic [127:0] exp_data, input int abase);
      int lat = -1;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         @(posedge clk); #1;
         bus.mem_gnt = (n <= seqlen) ? seq[n-1] : 1'b1;
         bus.instr_req = (mode == 2 && n < exp_lat) || (mode != 0 && n == exp_lat);
         bus.instr_addr = (n == exp_lat) ? nxt : pre;
         @(negedge clk);
         if (abase >= 0 && n <= 4) check({name, " word addr"}, bus.mem_addr, 128'(abase + n - 1));
         if (bus.instr_rvalid) lat = n;
      end
      check({name, " latency"}, 128'(lat), 128'(exp_lat));
      check({name, " line"}, bus.instr_rdata, exp_data);
      if (mode != 0) check({name, " b2b gnt"}, bus.instr_gnt, 1'b1);
   endtask
   localparam logic [127:0] L1 = 128'h10000007_10000006_10000005_10000004;
   localparam logic [127:0] L2 = 128'h1000000B_1000000A_10000009_10000008;
   localparam logic [127:0] L5 = 128'h10000017_10000016_10000015_10000014;
   initial begin
      int rv_seen;
      bus.instr_req = 1'b0;
      bus.instr_addr = '0;
      bus.mem_gnt = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset rdata", bus.instr_rdata, 128'h0);
      check("reset busy", bus.busy, 1'b0);
      rst_n = 1'b1;
      request(32'h10);
      run("single", 16'h0, 0, 0, 32'h0, 32'h0, 6, L1, 4);
      request(32'h10);
      run("stall", 16'b1011001, 7, 0, 32'h0, 32'h0, 9, L1, -1);
      request(32'h10);
      run("b2b first", 16'h0, 0, 1, 32'h0, 32'h20, 6, L1, -1);
      run("b2b second", 16'h0, 0, 0, 32'h0, 32'h0, 6, L2, 8);
      request(32'h10);
      run("redirect first", 16'h0, 0, 2, 32'h30, 32'h50, 6, L1, -1);
      run("redirect served", 16'h0, 0, 0, 32'h0, 32'h0, 6, L5, 20);
      request(32'h20);
      @(posedge clk); #1;
      bus.instr_req = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midreset outputs", {bus.instr_gnt, bus.instr_rvalid, bus.mem_req, bus.busy}, 4'h0);
      check("midreset rdata", bus.instr_rdata, 128'h0);
      check("midreset mem_addr", bus.mem_addr, 12'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rv_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.instr_rvalid) rv_seen++;
      end
      check("no rvalid after reset", 128'(rv_seen), 128'h0);
      request(32'h10);
      run("after reset", 16'h0, 0, 0, 32'h0, 32'h0, 6, L1, 4);
      request(32'h0000_4010);
      run("wrap", 16'h0, 0, 0, 32'h0, 32'h0, 6, L1, 4);
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
